mem_arbiter: RTL and testbench

//  Shares the single-ported RAM between the instruction fetch path (IF stage) and the data path (EX/MEM stage).

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access.
// Data has priority, bounded by a starvation counter; a watchdog aborts stalls.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic              r_wr;
  logic [SW-1:0]     r_starve;
  logic [WW-1:0]     r_wdog;
  logic              r_ihit;
  logic              r_dhit;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              r_err;

  logic w_dpend;
  logic w_ipend;
  logic w_starve_ok;
  logic w_wd_exp;
  logic w_grant_d;
  logic w_grant_i;
  logic w_done;
  logic w_abort;
  logic w_busy;

  // A requester is masked during its own hit so it is not re-granted.
  assign w_dpend     = (dREN | dWEN) & ~r_dhit;
  assign w_ipend     = iREN & ~r_ihit;
  assign w_starve_ok = r_starve < SW'(STARVE_MAX);
  assign w_wd_exp    = r_wdog == WW'(TIMEOUT - 1);
  assign w_busy      = r_state != IDLE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_dpend && (!w_ipend || w_starve_ok)) begin
          w_next    = DACC;
          w_grant_d = 1'b1;
        end else if (w_ipend) begin
          w_next    = IACC;
          w_grant_i = 1'b1;
        end
      end
      IACC, DACC: begin
        // ram_ready beats a simultaneous timeout
        if (ram_ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (w_wd_exp) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_starve <= '0;
      r_wdog   <= '0;
      r_ihit   <= 1'b0;
      r_dhit   <= 1'b0;
      r_iload  <= '0;
      r_dload  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      if (w_busy) r_wdog <= r_wdog + 1'b1;
      else        r_wdog <= '0;
      if (w_grant_d) begin
        r_addr  <= daddr;
        r_store <= dstore;
        r_wr    <= dWEN;
        if (iREN && r_starve != SW'(STARVE_MAX))
          r_starve <= r_starve + 1'b1;
      end
      if (w_grant_i) begin
        r_addr   <= iaddr;
        r_store  <= '0;
        r_wr     <= 1'b0;
        r_starve <= '0;
      end
      if (w_done) begin
        if (r_state == IACC) begin
          r_ihit  <= 1'b1;
          r_iload <= ram_load;
        end else begin
          r_dhit <= 1'b1;
          if (!r_wr) r_dload <= ram_load;
        end
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign ram_ren   = (r_state == IACC) | ((r_state == DACC) & ~r_wr);
  assign ram_wen   = (r_state == DACC) & r_wr;
  assign ram_addr  = w_busy ? r_addr : '0;
  assign ram_store = w_busy ? r_store : '0;
  assign ihit      = r_ihit;
  assign dhit      = r_dhit;
  assign iload     = r_iload;
  assign dload     = r_dload;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (STARVE_MAX=2, TIMEOUT=8).
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(2),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .iREN(iREN),
    .iaddr(iaddr),
    .ihit(ihit),
    .iload(iload),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dhit(dhit),
    .dload(dload),
    .ram_ren(ram_ren),
    .ram_wen(ram_wen),
    .ram_addr(ram_addr),
    .ram_store(ram_store),
    .ram_load(ram_load),
    .ram_ready(ram_ready),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  initial begin
    int run;
    int maxrun;
    int icnt;
    RST = 1'b1;
    iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
    daddr = 0; dstore = 0; ram_load = 0; ram_ready = 0;
    tick();
    tick();
    chk("rst_ren", ram_ren, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    chk("rst_err", err, 0);
    chk("rst_loads", iload | dload, 0);
    RST = 1'b0;

    // 1: instruction fetch, ready on third access cycle
    iREN = 1; iaddr = 32'h40;
    tick();
    chk("t1_ren_c1", ram_ren, 1);
    chk("t1_addr", ram_addr, 32'h40);
    tick();
    chk("t1_ren_c2", ram_ren, 1);
    tick();
    chk("t1_ren_c3", ram_ren, 1);
    chk("t1_nohit", ihit, 0);
    ram_ready = 1; ram_load = 32'h8C220004;
    tick();
    chk("t1_ihit", ihit, 1);
    chk("t1_iload", iload, 32'h8C220004);
    chk("t1_idle", ram_ren, 0);
    iREN = 0; ram_ready = 0;
    tick();
    chk("t1_pulse", ihit, 0);
    chk("t1_hold", iload, 32'h8C220004);

    // 2: simultaneous requests, data first
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    tick();
    chk("t2_daddr", ram_addr, 32'h100);
    chk("t2_dren", ram_ren, 1);
    ram_ready = 1; ram_load = 32'h11111111;
    tick();
    chk("t2_dhit", dhit, 1);
    chk("t2_dload", dload, 32'h11111111);
    chk("t2_bubble", ram_ren, 0);
    dREN = 0; ram_ready = 0;
    tick();
    chk("t2_iaddr", ram_addr, 32'h44);
    chk("t2_iren", ram_ren, 1);
    ram_ready = 1; ram_load = 32'h22222222;
    tick();
    chk("t2_ihit", ihit, 1);
    chk("t2_iload", iload, 32'h22222222);
    iREN = 0; ram_ready = 0;
    tick();

    // 3a: starvation cap -> D, D, then I despite data pending
    iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h104;
    tick();
    chk("t3_d1", ram_addr, 32'h104);
    ram_ready = 1;
    tick();
    chk("t3_d1hit", dhit, 1);
    iREN = 0; ram_ready = 0;
    tick();
    chk("t3_gap", ram_ren, 0);
    iREN = 1;
    tick();
    chk("t3_d2", ram_addr, 32'h104);
    ram_ready = 1;
    tick();
    chk("t3_d2hit", dhit, 1);
    iREN = 0; ram_ready = 0;
    tick();
    iREN = 1;
    tick();
    chk("t3_icap", ram_addr, 32'h48);
    chk("t3_icap_ren", ram_ren, 1);
    ram_ready = 1;
    tick();
    chk("t3_ihit", ihit, 1);
    iREN = 0; dREN = 0; ram_ready = 0;
    tick();
    chk("t3_end", ram_ren, 0);

    // 3b: both held; no instruction waits more than 2 data grants
    iaddr = 32'h4C; daddr = 32'h108; ram_load = 32'h33333333;
    iREN = 1; dREN = 1; ram_ready = 1;
    run = 0; maxrun = 0; icnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ram_ren && ram_addr == 32'h108) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else if (ram_ren && ram_addr == 32'h4C) begin
        icnt++;
        run = 0;
      end
    end
    chk("t3_starve", maxrun <= 2, 1);
    chk("t3_igrants", icnt >= 4, 1);
    iREN = 0; dREN = 0;
    tick();
    tick();
    ram_ready = 0;
    tick();

    // 4: write, dWEN wins over dREN
    dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick();
    chk("t4_wen", ram_wen, 1);
    chk("t4_ren", ram_ren, 0);
    chk("t4_store", ram_store, 32'hDEADBEEF);
    chk("t4_addr", ram_addr, 32'h200);
    ram_ready = 1; ram_load = 32'h55555555;
    tick();
    chk("t4_dhit", dhit, 1);
    chk("t4_dload", dload, 32'h33333333);
    chk("t4_idle", {ram_wen, ram_store}, 0);
    dWEN = 0; dREN = 0; ram_ready = 0;
    tick();

    // ready on the timeout cycle completes normally
    dREN = 1; daddr = 32'h300;
    tick();
    dREN = 0;
    repeat (6) tick();
    chk("tb_c7", ram_ren, 1);
    tick();
    chk("tb_c8", ram_ren, 1);
    ram_ready = 1; ram_load = 32'h77777777;
    tick();
    chk("tb_dhit", dhit, 1);
    chk("tb_dload", dload, 32'h77777777);
    chk("tb_noerr", err, 0);
    ram_ready = 0;
    tick();

    // 5: watchdog abort
    dREN = 1; daddr = 32'h304; ram_load = 32'h99999999;
    tick();
    dREN = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_ren_c%0d", i + 1), ram_ren, 1);
      tick();
    end
    chk("t5_idle", ram_ren, 0);
    chk("t5_nohit", dhit, 0);
    chk("t5_err", err, 1);
    chk("t5_dload", dload, 32'h77777777);
    tick();
    chk("t5_sticky", err, 1);
    iREN = 1; iaddr = 32'h60;
    tick();
    chk("t5_iren", ram_ren, 1);
    ram_ready = 1; ram_load = 32'h66666666;
    tick();
    chk("t5_ihit", ihit, 1);
    chk("t5_iload", iload, 32'h66666666);
    chk("t5_err2", err, 1);
    iREN = 0; ram_ready = 0;
    tick();

    // 6: async reset during an instruction access
    iREN = 1; iaddr = 32'h80;
    tick();
    tick();
    chk("t6_c2", ram_ren, 1);
    #2;
    RST = 1;
    #1;
    chk("t6_ren", ram_ren, 0);
    chk("t6_addr", ram_addr, 0);
    chk("t6_err", err, 0);
    chk("t6_loads", {ihit, iload}, 0);
    tick();
    chk("t6_nohit", ihit, 0);
    RST = 0;
    tick();
    chk("t6_regrant", ram_ren, 1);
    chk("t6_raddr", ram_addr, 32'h80);
    ram_ready = 1; ram_load = 32'h88888888;
    tick();
    chk("t6_ihit", ihit, 1);
    chk("t6_iload", iload, 32'h88888888);
    iREN = 0; ram_ready = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
